// File: rtl/llc_set_hazard_fifo.sv
// llc_set_hazard_fifo
// In-order FIFO between LLC pipeline stages. Each entry holds a set index and
// an opaque payload. Combinational set-hazard ports report whether any stored
// entry targets a queried set, so the decode stage can stall same-set requests.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. push_ready (== !full) and pop_valid (== !empty) depend only on stored
// state. While valid is high and ready is low, the offered entry and its
// valid stay stable until the transfer happens.
module llc_set_hazard_fifo #(
  parameter int DEPTH     = 4,
  parameter int SET_BITS  = 8,
  parameter int DATA_BITS = 64,
  parameter int CHK_PORTS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [SET_BITS-1:0]           push_set,
  input  logic [DATA_BITS-1:0]          push_data,
  output logic                          pop_valid,
  input  logic                          pop_ready,
  output logic [SET_BITS-1:0]           pop_set,
  output logic [DATA_BITS-1:0]          pop_data,
  input  logic [CHK_PORTS*SET_BITS-1:0] chk_set,
  output logic [CHK_PORTS-1:0]          chk_hit,
  output logic [$clog2(DEPTH):0]        usage,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [SET_BITS-1:0]  set_mem  [DEPTH];
  logic [DATA_BITS-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     usage_q;
  logic                 push_fire;
  logic                 pop_fire;

  // The counter alone decides full/empty; no pop->push bypass when full.
  assign full       = (usage_q == FULL_CNT);
  assign empty      = (usage_q == '0);
  assign usage      = usage_q;
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  // Head entry is read straight from the array: no fall-through path.
  assign pop_set  = set_mem[rd_ptr];
  assign pop_data = data_mem[rd_ptr];

  // Payload storage; contents are only meaningful where valid_q is set.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      set_mem[wr_ptr]  <= push_set;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointer, valid and occupancy bookkeeping; rst and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usage_q <= '0;
      valid_q <= '0;
    end else begin
      if (pop_fire) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
      if (push_fire) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   usage_q <= usage_q + CNT_W'(1);
        2'b01:   usage_q <= usage_q - CNT_W'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

  // Hazard check: stored entries only, so an entry being pushed this cycle is
  // not seen yet while one being popped this cycle still is.
  always_comb begin
    chk_hit = '0;
    for (int k = 0; k < CHK_PORTS; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (set_mem[i] == chk_set[k*SET_BITS +: SET_BITS])) begin
          chk_hit[k] = 1'b1;
        end
      end
    end
  end

  // Occupancy can never exceed DEPTH and always matches the number of valid slots.
  assert property (@(posedge clk) disable iff (rst) usage_q <= FULL_CNT);
  assert property (@(posedge clk) disable iff (rst) $countones(valid_q) == int'(usage_q));

endmodule

// File: tb/tb_llc_set_hazard_fifo.sv
// Testbench for llc_set_hazard_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_llc_set_hazard_fifo;

  localparam int DEPTH     = 4;
  localparam int SET_BITS  = 8;
  localparam int DATA_BITS = 64;
  localparam int CHK_PORTS = 2;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          flush;
  logic                          push_valid;
  logic                          push_ready;
  logic [SET_BITS-1:0]           push_set;
  logic [DATA_BITS-1:0]          push_data;
  logic                          pop_valid;
  logic                          pop_ready;
  logic [SET_BITS-1:0]           pop_set;
  logic [DATA_BITS-1:0]          pop_data;
  logic [CHK_PORTS*SET_BITS-1:0] chk_set;
  logic [CHK_PORTS-1:0]          chk_hit;
  logic [2:0]                    usage;
  logic                          full;
  logic                          empty;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents in order, head at index 0.
  logic [SET_BITS-1:0]  m_set  [$];
  logic [DATA_BITS-1:0] m_data [$];

  llc_set_hazard_fifo #(
    .DEPTH(DEPTH), .SET_BITS(SET_BITS), .DATA_BITS(DATA_BITS), .CHK_PORTS(CHK_PORTS)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_set(push_set), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_set(pop_set), .pop_data(pop_data),
    .chk_set(chk_set), .chk_hit(chk_hit), .usage(usage), .full(full), .empty(empty)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle();
    rst        = 1'b0;
    flush      = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    push_set   = '0;
    push_data  = '0;
    chk_set    = '0;
  endtask

  // One clock: update the model from the inputs seen at the edge, then
  // return at the next falling edge where new inputs are driven.
  task automatic tick();
    bit pf;
    bit qf;
    @(posedge clk);
    pf = push_valid && (m_set.size() < DEPTH);
    qf = pop_ready && (m_set.size() > 0);
    if (rst || flush) begin
      m_set.delete();
      m_data.delete();
    end else begin
      if (qf) begin
        void'(m_set.pop_front());
        void'(m_data.pop_front());
      end
      if (pf) begin
        m_set.push_back(push_set);
        m_data.push_back(push_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic push_one(input logic [SET_BITS-1:0] s, input logic [DATA_BITS-1:0] d);
    push_valid = 1'b1;
    push_set   = s;
    push_data  = d;
    tick();
    push_valid = 1'b0;
  endtask

  function automatic logic [CHK_PORTS-1:0] model_hit(input logic [CHK_PORTS*SET_BITS-1:0] cs);
    logic [CHK_PORTS-1:0] h;
    h = '0;
    for (int k = 0; k < CHK_PORTS; k++) begin
      foreach (m_set[i]) begin
        if (m_set[i] == cs[k*SET_BITS +: SET_BITS]) h[k] = 1'b1;
      end
    end
    return h;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst        = 1'b1;
    push_valid = 1'b1;
    push_set   = 8'hAA;
    tick();
    tick();
    idle();
    chk_set = {8'hAA, 8'h00};
    #1;
    if (push_ready !== 1'b1) begin $display("FAIL reset_push_ready: got %b want 1", push_ready); n_errors++; end
    n_checks++;
    if (pop_valid !== 1'b0) begin $display("FAIL reset_pop_valid: got %b want 0", pop_valid); n_errors++; end
    n_checks++;
    if (full !== 1'b0) begin $display("FAIL reset_full: got %b want 0", full); n_errors++; end
    n_checks++;
    if (empty !== 1'b1) begin $display("FAIL reset_empty: got %b want 1", empty); n_errors++; end
    n_checks++;
    if (usage !== 3'd0) begin $display("FAIL reset_usage: got %0d want 0", usage); n_errors++; end
    n_checks++;
    if (chk_hit !== 2'b00) begin $display("FAIL reset_chk_hit: got %b want 00", chk_hit); n_errors++; end
    n_checks++;
  endtask

  task automatic test_order();
    logic [7:0] exp_s [3];
    exp_s[0] = 8'h11; exp_s[1] = 8'h22; exp_s[2] = 8'h33;
    for (int i = 0; i < 3; i++) push_one(exp_s[i], {56'd0, exp_s[i]});
    #1;
    if (usage !== 3'd3) begin $display("FAIL order_usage3: got %0d want 3", usage); n_errors++; end
    n_checks++;
    pop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (pop_valid !== 1'b1) begin $display("FAIL order_pop_valid[%0d]: got %b want 1", i, pop_valid); n_errors++; end
      n_checks++;
      if (pop_set !== exp_s[i]) begin $display("FAIL order_pop_set[%0d]: got %h want %h", i, pop_set, exp_s[i]); n_errors++; end
      n_checks++;
      if (pop_data !== {56'd0, exp_s[i]}) begin $display("FAIL order_pop_data[%0d]: got %h want %h", i, pop_data, exp_s[i]); n_errors++; end
      n_checks++;
      if (usage !== 3'(3 - i)) begin $display("FAIL order_usage[%0d]: got %0d want %0d", i, usage, 3 - i); n_errors++; end
      n_checks++;
      tick();
    end
    pop_ready = 1'b0;
    #1;
    if (usage !== 3'd0) begin $display("FAIL order_usage_end: got %0d want 0", usage); n_errors++; end
    n_checks++;
    if (empty !== 1'b1) begin $display("FAIL order_empty_end: got %b want 1", empty); n_errors++; end
    n_checks++;
  endtask

  task automatic test_full();
    logic [7:0] exp_s [4];
    exp_s[0] = 8'h41; exp_s[1] = 8'h42; exp_s[2] = 8'h43; exp_s[3] = 8'h99;
    for (int i = 0; i < 4; i++) push_one(8'(8'h40 + i), 64'(i));
    #1;
    if (full !== 1'b1) begin $display("FAIL full_flag: got %b want 1", full); n_errors++; end
    n_checks++;
    if (push_ready !== 1'b0) begin $display("FAIL full_push_ready: got %b want 0", push_ready); n_errors++; end
    n_checks++;
    // Fifth push is held while full.
    push_valid = 1'b1;
    push_set   = 8'h99;
    push_data  = 64'h99;
    tick();
    tick();
    #1;
    if (usage !== 3'd4) begin $display("FAIL full_held_usage: got %0d want 4", usage); n_errors++; end
    n_checks++;
    // Pop while full with push offered: only the pop fires.
    pop_ready = 1'b1;
    #1;
    if (pop_set !== 8'h40) begin $display("FAIL full_head: got %h want 40", pop_set); n_errors++; end
    n_checks++;
    tick();
    pop_ready = 1'b0;
    #1;
    if (usage !== 3'd3) begin $display("FAIL full_pop_only_usage: got %0d want 3", usage); n_errors++; end
    n_checks++;
    if (push_ready !== 1'b1) begin $display("FAIL full_ready_after_pop: got %b want 1", push_ready); n_errors++; end
    n_checks++;
    tick();
    push_valid = 1'b0;
    #1;
    if (usage !== 3'd4) begin $display("FAIL full_refill_usage: got %0d want 4", usage); n_errors++; end
    n_checks++;
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (pop_set !== exp_s[i]) begin $display("FAIL full_drain[%0d]: got %h want %h", i, pop_set, exp_s[i]); n_errors++; end
      n_checks++;
      tick();
    end
    pop_ready = 1'b0;
  endtask

  task automatic test_hazard();
    chk_set    = {8'h00, 8'h5A};
    push_valid = 1'b1;
    push_set   = 8'h5A;
    push_data  = 64'h5A;
    #1;
    if (chk_hit[0] !== 1'b0) begin $display("FAIL hazard_same_cycle: got %b want 0", chk_hit[0]); n_errors++; end
    n_checks++;
    tick();
    push_valid = 1'b0;
    #1;
    if (chk_hit[0] !== 1'b1) begin $display("FAIL hazard_next_cycle: got %b want 1", chk_hit[0]); n_errors++; end
    n_checks++;
    pop_ready = 1'b1;
    #1;
    if (chk_hit[0] !== 1'b1) begin $display("FAIL hazard_pop_cycle: got %b want 1", chk_hit[0]); n_errors++; end
    n_checks++;
    tick();
    pop_ready = 1'b0;
    #1;
    if (chk_hit[0] !== 1'b0) begin $display("FAIL hazard_after_pop: got %b want 0", chk_hit[0]); n_errors++; end
    n_checks++;
    chk_set = '0;
  endtask

  task automatic test_back_to_back();
    push_one(8'($urandom_range(0, 255)), {$urandom, $urandom});
    push_one(8'($urandom_range(0, 255)), {$urandom, $urandom});
    for (int c = 0; c < 20; c++) begin
      push_valid = 1'b1;
      pop_ready  = 1'b1;
      push_set   = 8'($urandom_range(0, 255));
      push_data  = {$urandom, $urandom};
      #1;
      if (pop_set !== m_set[0]) begin $display("FAIL b2b_set[%0d]: got %h want %h", c, pop_set, m_set[0]); n_errors++; end
      n_checks++;
      if (pop_data !== m_data[0]) begin $display("FAIL b2b_data[%0d]: got %h want %h", c, pop_data, m_data[0]); n_errors++; end
      n_checks++;
      if (usage !== 3'd2) begin $display("FAIL b2b_usage[%0d]: got %0d want 2", c, usage); n_errors++; end
      n_checks++;
      tick();
    end
    push_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (pop_set !== m_set[0]) begin $display("FAIL b2b_drain[%0d]: got %h want %h", c, pop_set, m_set[0]); n_errors++; end
      n_checks++;
      tick();
    end
    pop_ready = 1'b0;
  endtask

  task automatic test_flush();
    push_one(8'h71, 64'h71);
    push_one(8'h72, 64'h72);
    push_one(8'h73, 64'h73);
    flush      = 1'b1;
    push_valid = 1'b1;
    push_set   = 8'h74;
    push_data  = 64'h74;
    chk_set    = {8'h74, 8'h71};
    #1;
    if (push_ready !== 1'b1) begin $display("FAIL flush_ready_kept: got %b want 1", push_ready); n_errors++; end
    n_checks++;
    tick();
    flush      = 1'b0;
    push_valid = 1'b0;
    #1;
    if (usage !== 3'd0) begin $display("FAIL flush_usage: got %0d want 0", usage); n_errors++; end
    n_checks++;
    if (empty !== 1'b1 || pop_valid !== 1'b0) begin $display("FAIL flush_empty: got empty=%b pop_valid=%b want 1/0", empty, pop_valid); n_errors++; end
    n_checks++;
    if (chk_hit !== 2'b00) begin $display("FAIL flush_chk_hit: got %b want 00", chk_hit); n_errors++; end
    n_checks++;
    chk_set = '0;
  endtask

  task automatic test_multi_chk();
    push_one(8'h10, 64'h10);
    push_one(8'h20, 64'h20);
    chk_set = {8'h30, 8'h20};
    #1;
    if (chk_hit !== 2'b01) begin $display("FAIL multi_chk_hit: got %b want 01", chk_hit); n_errors++; end
    n_checks++;
    rst        = 1'b1;
    push_valid = 1'b1;
    push_set   = 8'h30;
    pop_ready  = 1'b1;
    tick();
    idle();
    chk_set = {8'h30, 8'h20};
    #1;
    if (usage !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin $display("FAIL midrst_state: got usage=%0d empty=%b full=%b want 0/1/0", usage, empty, full); n_errors++; end
    n_checks++;
    if (pop_valid !== 1'b0 || push_ready !== 1'b1) begin $display("FAIL midrst_hs: got pop_valid=%b push_ready=%b want 0/1", pop_valid, push_ready); n_errors++; end
    n_checks++;
    if (chk_hit !== 2'b00) begin $display("FAIL midrst_chk_hit: got %b want 00", chk_hit); n_errors++; end
    n_checks++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush      = ($urandom_range(0, 29) == 0);
      push_valid = ($urandom_range(0, 2) != 0);
      pop_ready  = ($urandom_range(0, 2) != 0);
      push_set   = 8'($urandom_range(0, 7));
      push_data  = {$urandom, $urandom};
      chk_set    = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))};
      #1;
      if (usage !== 3'(m_set.size())) begin $display("FAIL rnd_usage[%0d]: got %0d want %0d", c, usage, m_set.size()); n_errors++; end
      n_checks++;
      if (full !== (m_set.size() == DEPTH) || push_ready !== (m_set.size() != DEPTH)) begin
        $display("FAIL rnd_full[%0d]: got full=%b push_ready=%b want size %0d", c, full, push_ready, m_set.size()); n_errors++;
      end
      n_checks++;
      if (empty !== (m_set.size() == 0) || pop_valid !== (m_set.size() != 0)) begin
        $display("FAIL rnd_empty[%0d]: got empty=%b pop_valid=%b want size %0d", c, empty, pop_valid, m_set.size()); n_errors++;
      end
      n_checks++;
      if (chk_hit !== model_hit(chk_set)) begin $display("FAIL rnd_chk_hit[%0d]: got %b want %b", c, chk_hit, model_hit(chk_set)); n_errors++; end
      n_checks++;
      if (m_set.size() > 0) begin
        if (pop_set !== m_set[0] || pop_data !== m_data[0]) begin
          $display("FAIL rnd_head[%0d]: got %h/%h want %h/%h", c, pop_set, pop_data, m_set[0], m_data[0]); n_errors++;
        end
        n_checks++;
      end
      tick();
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_order();
    test_full();
    test_hazard();
    test_back_to_back();
    test_flush();
    test_multi_chk();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
